traffic_phase_controller: RTL and testbench

//  Sequences a two-road (NS/EW) intersection through green/yellow/all-red phases.

---
 rtl/traffic_phase_controller_pkg.sv | 39 +++
 rtl/traffic_phase_controller_tick_prescaler.sv | 25 ++
 rtl/traffic_phase_controller.sv | 142 ++++++++++++++
 tb/tb_traffic_phase_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_phase_controller_pkg.sv
// Shared definitions for the traffic phase controller.
//   - phase encodings (3-bit, also driven on the debug phase output)
//   - lamp codes, ordered {red,yellow,green}
//   - next_phase(): the fixed cyclic phase order
//   - max3(): helper for sizing the phase timer
package traffic_phase_controller_pkg;

  localparam logic [2:0] S_NS_G  = 3'd0;
  localparam logic [2:0] S_NS_Y  = 3'd1;
  localparam logic [2:0] S_AR_NS = 3'd2;
  localparam logic [2:0] S_EW_G  = 3'd3;
  localparam logic [2:0] S_EW_Y  = 3'd4;
  localparam logic [2:0] S_AR_EW = 3'd5;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Unused codes fall back to NS green, so an upset flop self-recovers.
  function automatic logic [2:0] next_phase(input logic [2:0] s);
    case (s)
      S_NS_G:  next_phase = S_NS_Y;
      S_NS_Y:  next_phase = S_AR_NS;
      S_AR_NS: next_phase = S_EW_G;
      S_EW_G:  next_phase = S_EW_Y;
      S_EW_Y:  next_phase = S_AR_EW;
      default: next_phase = S_NS_G;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_tick_prescaler.sv
// tick_prescaler: divides the system clock down to the timing tick.
//   clock  in   system clock
//   reset  in   asynchronous, active-high reset
//   tick   out  high for one cycle every DIV cycles (count == DIV-1)
module tick_prescaler #(
  parameter int DIV = 27000000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CW'(DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: two-road intersection sequencer with
// pedestrian walk service.
//   clock     in   system clock
//   reset     in   asynchronous, active-high reset
//   ped_req   in   [2]  debounced button levels, [0]=NS crosswalk, [1]=EW crosswalk
//   ns_light  out  [3]  NS lamps {red,yellow,green}, one-hot
//   ew_light  out  [3]  EW lamps {red,yellow,green}, one-hot
//   walk      out  [2]  walk signal per crosswalk
//   pending   out  [2]  latched requests not yet served
//   phase     out  [3]  current state code (debug)
//
// state   | meaning
// S_NS_G  | NS green, EW red; may end early on EW crosswalk request
// S_NS_Y  | NS yellow, EW red
// S_AR_NS | all red after NS
// S_EW_G  | EW green, NS red; may end early on NS crosswalk request
// S_EW_Y  | EW yellow, NS red
// S_AR_EW | all red after EW (reset state)
module traffic_phase_controller
  import traffic_phase_controller_pkg::*;
#(
  parameter int TICK_DIV    = 27000000,
  parameter int T_GREEN     = 20,
  parameter int T_GREEN_MIN = 5,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [1:0] walk,
  output logic [1:0] pending,
  output logic [2:0] phase
);

  localparam int T_MAX = max3(T_GREEN, T_YELLOW, T_ALLRED);
  // Sized to hold T_MAX itself so T_WALK and T_GREEN_MIN compare without truncation.
  localparam int TW = $clog2(T_MAX + 1);
  localparam logic [TW-1:0] GMIN_M1 = TW'(T_GREEN_MIN - 1);
  localparam logic [TW-1:0] WALK_T  = TW'(T_WALK);

  logic          tick;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    pend_q, pend_d;
  logic [1:0]    walk_act_q, walk_act_d;
  logic [1:0]    ped_req_q;
  logic [1:0]    req_edge;
  logic [1:0]    clr;
  logic          advance;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  function automatic logic [TW-1:0] last_tick(input logic [2:0] s);
    case (s)
      S_NS_G, S_EW_G: last_tick = TW'(T_GREEN - 1);
      S_NS_Y, S_EW_Y: last_tick = TW'(T_YELLOW - 1);
      default:        last_tick = TW'(T_ALLRED - 1);
    endcase
  endfunction

  assign req_edge = ped_req & ~ped_req_q;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    walk_act_d = walk_act_q;
    clr        = 2'b00;
    advance    = 1'b0;

    if (tick) begin
      if (timer_q == last_tick(state_q))
        advance = 1'b1;
      else if (state_q == S_NS_G && (pend_q[1] | req_edge[1]) && timer_q >= GMIN_M1)
        advance = 1'b1;
      else if (state_q == S_EW_G && (pend_q[0] | req_edge[0]) && timer_q >= GMIN_M1)
        advance = 1'b1;

      if (advance) begin
        state_d = next_phase(state_q);
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    // Serve a road's crosswalk on the cycle its green begins; an edge that
    // arrives in that same cycle is served here rather than left pending.
    if (state_d == S_NS_G && state_q != S_NS_G) begin
      clr[0]        = 1'b1;
      walk_act_d[0] = pend_q[0] | req_edge[0];
    end
    if (state_d == S_EW_G && state_q != S_EW_G) begin
      clr[1]        = 1'b1;
      walk_act_d[1] = pend_q[1] | req_edge[1];
    end

    pend_d = (pend_q | req_edge) & ~clr;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_AR_EW;
      timer_q    <= '0;
      pend_q     <= 2'b00;
      walk_act_q <= 2'b00;
      ped_req_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pend_q     <= pend_d;
      walk_act_q <= walk_act_d;
      ped_req_q  <= ped_req;
    end
  end

  // Moore decode; unused state codes show all red.
  always_comb begin
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    case (state_q)
      S_NS_G:  ns_light = LAMP_GRN;
      S_NS_Y:  ns_light = LAMP_YEL;
      S_EW_G:  ew_light = LAMP_GRN;
      S_EW_Y:  ew_light = LAMP_YEL;
      default: ;
    endcase
  end

  assign walk[0] = (state_q == S_NS_G) && walk_act_q[0] && (timer_q < WALK_T);
  assign walk[1] = (state_q == S_EW_G) && walk_act_q[1] && (timer_q < WALK_T);
  assign pending = pend_q;
  assign phase   = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with short timing
// (TICK_DIV=4, T_GREEN=6, T_GREEN_MIN=2, T_YELLOW=2, T_ALLRED=1, T_WALK=2).
// Phase lengths in cycles: green 24, yellow 8, all-red 4, cut green 8.
module tb_traffic_phase_controller;
  import traffic_phase_controller_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] ped_req = 2'b00;
  logic [2:0] ns_light, ew_light, phase;
  logic [1:0] walk, pending;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_phase_controller #(
    .TICK_DIV(4), .T_GREEN(6), .T_GREEN_MIN(2),
    .T_YELLOW(2), .T_ALLRED(1), .T_WALK(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .pending  (pending),
    .phase    (phase)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_ns(input logic [2:0] ph);
    if (ph == S_NS_G) return 3'b001;
    if (ph == S_NS_Y) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_ew(input logic [2:0] ph);
    if (ph == S_EW_G) return 3'b001;
    if (ph == S_EW_Y) return 3'b010;
    return 3'b100;
  endfunction

  // Called at a negedge; counts remaining cycles of phase ph and stops at
  // the negedge where the next phase is first visible.
  task automatic run_phase(input string tag, input logic [2:0] ph,
                           input int exp_len, input int exp_walk);
    int len = 0;
    int wcyc = 0;
    int bad = 0;
    logic [1:0] allowed;
    allowed = (ph == S_NS_G) ? 2'b01 : (ph == S_EW_G) ? 2'b10 : 2'b00;
    check_val({tag, "_phase"}, 32'(phase), 32'(ph));
    while (phase == ph && len < 200) begin
      if (ns_light !== exp_ns(ph) || ew_light !== exp_ew(ph)) bad++;
      if ((walk & ~allowed) != 2'b00) bad++;
      if (walk != 2'b00) wcyc++;
      @(negedge clock);
      len++;
    end
    check_val({tag, "_len"}, 32'(len), 32'(exp_len));
    check_val({tag, "_lamps"}, 32'(bad), 32'd0);
    check_val({tag, "_walk"}, 32'(wcyc), 32'(exp_walk));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clock);
    check_val("rst_ns", 32'(ns_light), 32'h4);
    check_val("rst_ew", 32'(ew_light), 32'h4);
    check_val("rst_walk", 32'(walk), 32'd0);
    check_val("rst_pend", 32'(pending), 32'd0);
    check_val("rst_phase", 32'(phase), 32'(S_AR_EW));
    @(negedge clock);
    reset = 1'b0;

    // Idle: NS green four cycles after release, then one full 72-cycle cycle
    run_phase("boot_ar", S_AR_EW, 4, 0);
    run_phase("idle_nsg", S_NS_G, 24, 0);
    run_phase("idle_nsy", S_NS_Y, 8, 0);
    run_phase("idle_arn", S_AR_NS, 4, 0);
    run_phase("idle_ewg", S_EW_G, 24, 0);
    run_phase("idle_ewy", S_EW_Y, 8, 0);
    run_phase("idle_are", S_AR_EW, 4, 0);

    // Own-road request at NS green timer=1: no shortening, stays pending
    repeat (5) @(negedge clock);
    ped_req = 2'b01;
    @(negedge clock);
    check_val("own_pend", 32'(pending), 32'h1);
    ped_req = 2'b00;
    run_phase("own_nsg", S_NS_G, 18, 0);
    run_phase("own_nsy", S_NS_Y, 8, 0);
    run_phase("own_arn", S_AR_NS, 4, 0);
    check_val("own_pend_ew", 32'(pending), 32'h1);
    run_phase("own_ewg_cut", S_EW_G, 8, 0);
    run_phase("own_ewy", S_EW_Y, 8, 0);
    run_phase("own_are", S_AR_EW, 4, 0);
    check_val("own_served", 32'(pending), 32'h0);
    run_phase("own_nsg_walk", S_NS_G, 24, 8);
    run_phase("own_nsy2", S_NS_Y, 8, 0);
    run_phase("own_arn2", S_AR_NS, 4, 0);

    // Early end: request at EW green tick 0
    ped_req = 2'b01;
    @(negedge clock);
    check_val("early_pend", 32'(pending), 32'h1);
    ped_req = 2'b00;
    run_phase("early_ewg", S_EW_G, 7, 0);
    run_phase("early_ewy", S_EW_Y, 8, 0);
    run_phase("early_are", S_AR_EW, 4, 0);
    check_val("early_clr", 32'(pending), 32'h0);
    run_phase("early_nsg", S_NS_G, 24, 8);
    run_phase("early_nsy", S_NS_Y, 8, 0);
    run_phase("early_arn", S_AR_NS, 4, 0);

    // Late request: EW green timer=4, ends at the next tick
    repeat (17) @(negedge clock);
    ped_req = 2'b01;
    @(negedge clock);
    check_val("late_pend", 32'(pending), 32'h1);
    ped_req = 2'b00;
    run_phase("late_ewg", S_EW_G, 2, 0);
    run_phase("late_ewy", S_EW_Y, 8, 0);
    run_phase("late_are", S_AR_EW, 4, 0);
    run_phase("late_nsg", S_NS_G, 24, 8);
    run_phase("late_nsy", S_NS_Y, 8, 0);
    run_phase("late_arn", S_AR_NS, 4, 0);
    run_phase("late_ewg2", S_EW_G, 24, 0);
    run_phase("late_ewy2", S_EW_Y, 8, 0);

    // Simultaneous: both buttons rise in all-red and are held 100 cycles
    fork
      begin
        ped_req = 2'b11;
        repeat (100) @(negedge clock);
        ped_req = 2'b00;
      end
    join_none
    @(negedge clock);
    check_val("sim_pend", 32'(pending), 32'h3);
    run_phase("sim_are", S_AR_EW, 3, 0);
    check_val("sim_pend_ns", 32'(pending), 32'h2);
    run_phase("sim_nsg_cut", S_NS_G, 8, 8);
    run_phase("sim_nsy", S_NS_Y, 8, 0);
    run_phase("sim_arn", S_AR_NS, 4, 0);
    check_val("sim_pend_ew", 32'(pending), 32'h0);
    run_phase("sim_ewg", S_EW_G, 24, 8);
    run_phase("sim_ewy", S_EW_Y, 8, 0);
    run_phase("sim_are2", S_AR_EW, 4, 0);
    run_phase("hold_nsg", S_NS_G, 24, 0);
    run_phase("hold_nsy", S_NS_Y, 8, 0);
    run_phase("hold_arn", S_AR_NS, 4, 0);
    run_phase("hold_ewg", S_EW_G, 24, 0);
    check_val("hold_pend", 32'(pending), 32'h0);

    // Reset asserted between edges in the middle of EW yellow
    repeat (2) @(negedge clock);
    ped_req = 2'b01;
    @(negedge clock);
    check_val("ry_pend", 32'(pending), 32'h1);
    check_val("ry_phase", 32'(phase), 32'(S_EW_Y));
    #2;
    reset = 1'b1;
    #1;
    check_val("ry_ns", 32'(ns_light), 32'h4);
    check_val("ry_ew", 32'(ew_light), 32'h4);
    check_val("ry_walk", 32'(walk), 32'd0);
    check_val("ry_pend0", 32'(pending), 32'h0);
    check_val("ry_phase_rst", 32'(phase), 32'(S_AR_EW));
    ped_req = 2'b00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    run_phase("rs_ar", S_AR_EW, 4, 0);
    run_phase("rs_nsg", S_NS_G, 24, 0);
    run_phase("rs_nsy", S_NS_Y, 8, 0);
    check_val("rs_pend", 32'(pending), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
